// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - WIDTH-bit Fibonacci/Galois LFSR with divided auto-step, seed load and period measurement
//
// Ports:
//   clk_50m    in   1      system clock
//   rst        in   1      asynchronous active-high reset
//   seed       in   WIDTH  seed value captured on load
//   load       in   1      synchronous seed load strobe (highest priority)
//   run        in   1      level enable for divider-driven auto stepping
//   step       in   1      single-cycle manual step strobe
//   state      out  WIDTH  current LFSR value
//   advance    out  1      pulse in the cycle after the state changed
//   wrap       out  1      pulse (with advance) when the new state equals the reference seed
//   period     out  WIDTH  step count of the last completed cycle, 0 until the first wrap
//   seed_fixed out  1      last load carried an all-zero seed that was replaced by 1

module lfsr_gen #(
   parameter int               WIDTH    = 8,
   parameter bit               MODE     = 1'b0,
   parameter logic [WIDTH-1:0] FIB_TAPS = 8'hB8,
   parameter logic [WIDTH-1:0] GAL_POLY = 8'h71,
   parameter int               CLK_DIV  = 50_000_000,
   parameter logic [WIDTH-1:0] SEED_RST = {{(WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic [WIDTH-1:0] seed,
   input  logic             load,
   input  logic             run,
   input  logic             step,
   output logic [WIDTH-1:0] state,
   output logic             advance,
   output logic             wrap,
   output logic [WIDTH-1:0] period,
   output logic             seed_fixed
);

   localparam int               DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             advance_q, advance_d;
   logic             wrap_q, wrap_d;
   logic             seed_fixed_q, seed_fixed_d;

   logic             tick;
   logic             do_step;
   logic             seed_zero;
   logic             fib_fb;
   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] next_state;
   logic [WIDTH-1:0] count_inc;

   always_comb begin
      fib_fb     = ^(state_q & FIB_TAPS);
      fib_next   = {state_q[WIDTH-2:0], fib_fb};
      gal_next   = {state_q[WIDTH-2:0], 1'b0} ^ (state_q[WIDTH-1] ? GAL_POLY : '0);
      next_state = MODE ? gal_next : fib_next;
      seed_zero  = (seed == '0);
      count_inc  = count_q + 1'b1;
      tick       = run && (div_q == DIV_MAX);
      // A tick landing on a manual step or a load is swallowed, never queued.
      do_step    = !load && (step || tick);
   end

   always_comb begin
      state_d      = state_q;
      ref_d        = ref_q;
      count_d      = count_q;
      period_d     = period_q;
      div_d        = div_q;
      advance_d    = 1'b0;
      wrap_d       = 1'b0;
      seed_fixed_d = seed_fixed_q;

      if (load) begin
         div_d = '0;
      end else if (run) begin
         div_d = tick ? '0 : div_q + 1'b1;
      end

      if (load) begin
         // Zero would lock the register, so it is replaced by 1 and flagged.
         state_d      = seed_zero ? ONE : seed;
         ref_d        = seed_zero ? ONE : seed;
         seed_fixed_d = seed_zero;
         count_d      = '0;
      end else if (do_step) begin
         state_d   = next_state;
         advance_d = 1'b1;
         if (next_state == ref_q) begin
            wrap_d   = 1'b1;
            period_d = count_inc;
            count_d  = '0;
         end else begin
            count_d  = count_inc;
         end
      end
   end

   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         state_q      <= SEED_RST;
         ref_q        <= SEED_RST;
         count_q      <= '0;
         period_q     <= '0;
         div_q        <= '0;
         advance_q    <= 1'b0;
         wrap_q       <= 1'b0;
         seed_fixed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ref_q        <= ref_d;
         count_q      <= count_d;
         period_q     <= period_d;
         div_q        <= div_d;
         advance_q    <= advance_d;
         wrap_q       <= wrap_d;
         seed_fixed_q <= seed_fixed_d;
      end
   end

   assign state      = state_q;
   assign advance    = advance_q;
   assign wrap       = wrap_q;
   assign period     = period_q;
   assign seed_fixed = seed_fixed_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed bench for lfsr_gen in Fibonacci and Galois form

module tb_lfsr_gen;

   logic       clk_50m = 1'b0;
   logic       rst     = 1'b1;
   logic [7:0] seed    = 8'h00;
   logic       load    = 1'b0;
   logic       run     = 1'b0;
   logic       step    = 1'b0;

   logic [7:0] state_f, period_f, state_g, period_g;
   logic       adv_f, wrap_f, sfix_f, adv_g, wrap_g, sfix_g;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk_50m = ~clk_50m;

   lfsr_gen #(.WIDTH(8), .MODE(1'b0), .CLK_DIV(4)) dut_f (
      .clk_50m(clk_50m), .rst(rst), .seed(seed), .load(load), .run(run), .step(step),
      .state(state_f), .advance(adv_f), .wrap(wrap_f), .period(period_f), .seed_fixed(sfix_f)
   );

   lfsr_gen #(.WIDTH(8), .MODE(1'b1), .CLK_DIV(4)) dut_g (
      .clk_50m(clk_50m), .rst(rst), .seed(seed), .load(load), .run(run), .step(step),
      .state(state_g), .advance(adv_g), .wrap(wrap_g), .period(period_g), .seed_fixed(sfix_g)
   );

   task automatic cyc();
      @(posedge clk_50m);
      #1;
   endtask

   task automatic test_reset();
      #12;
      tests_run++;
      if (state_f !== 8'h01 || period_f !== 8'h00 || adv_f !== 1'b0 || wrap_f !== 1'b0 || sfix_f !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_fib: state=%h period=%h adv=%b wrap=%b sfix=%b, want 01 00 0 0 0",
                  state_f, period_f, adv_f, wrap_f, sfix_f);
      end
      tests_run++;
      if (state_g !== 8'h01 || period_g !== 8'h00 || adv_g !== 1'b0 || wrap_g !== 1'b0 || sfix_g !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_gal: state=%h period=%h adv=%b wrap=%b sfix=%b, want 01 00 0 0 0",
                  state_g, period_g, adv_g, wrap_g, sfix_g);
      end
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_fib_run();
      logic [7:0] exp_seq [5];
      int n;
      exp_seq = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
      seed = 8'h01; load = 1'b1; run = 1'b1;
      cyc();
      load = 1'b0;
      tests_run++;
      if (state_f !== 8'h01 || adv_f !== 1'b0) begin
         tests_failed++;
         $display("FAIL fib_load: state=%h adv=%b, want 01 0", state_f, adv_f);
      end
      for (int i = 0; i < 5; i++) begin
         n = 0;
         do begin
            cyc();
            n++;
         end while (adv_f !== 1'b1 && n < 10);
         tests_run++;
         if (state_f !== exp_seq[i] || n != 4) begin
            tests_failed++;
            $display("FAIL fib_step%0d: state=%h after %0d cycles, want %h after 4", i, state_f, n, exp_seq[i]);
         end
      end
      run = 1'b0;
      cyc();
      tests_run++;
      if (adv_f !== 1'b0 || state_f !== 8'h23) begin
         tests_failed++;
         $display("FAIL fib_adv_pulse: adv=%b state=%h, want 0 23", adv_f, state_f);
      end
   endtask

   task automatic test_galois_step();
      logic [7:0] exp_seq [10];
      exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h71, 8'hE2, 8'hB5};
      seed = 8'h01; load = 1'b1;
      cyc();
      load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step = 1'b1;
         cyc();
         step = 1'b0;
         tests_run++;
         if (state_g !== exp_seq[i] || adv_g !== 1'b1) begin
            tests_failed++;
            $display("FAIL gal_step%0d: state=%h adv=%b, want %h 1", i, state_g, adv_g, exp_seq[i]);
         end
      end
      cyc();
      tests_run++;
      if (state_g !== 8'hB5 || adv_g !== 1'b0) begin
         tests_failed++;
         $display("FAIL gal_hold: state=%h adv=%b, want b5 0", state_g, adv_g);
      end
   endtask

   task automatic test_period();
      int n;
      int bad_wraps = 0;
      bit timed_out = 1'b0;
      seed = 8'h5A; load = 1'b1; run = 1'b1;
      cyc();
      load = 1'b0;
      for (int k = 1; k <= 510 && !timed_out; k++) begin
         n = 0;
         do begin
            cyc();
            n++;
         end while (adv_f !== 1'b1 && n < 8);
         if (adv_f !== 1'b1) timed_out = 1'b1;
         if (k == 254) begin
            tests_run++;
            if (period_f !== 8'h00 || wrap_f !== 1'b0) begin
               tests_failed++;
               $display("FAIL period_before_wrap: period=%h wrap=%b, want 00 0", period_f, wrap_f);
            end
         end else if (k == 255 || k == 510) begin
            tests_run++;
            if (state_f !== 8'h5A || wrap_f !== 1'b1 || period_f !== 8'd255) begin
               tests_failed++;
               $display("FAIL period_wrap_at_%0d: state=%h wrap=%b period=%0d, want 5a 1 255",
                        k, state_f, wrap_f, period_f);
            end
         end else if (wrap_f !== 1'b0) begin
            bad_wraps++;
         end
      end
      run = 1'b0;
      tests_run++;
      if (timed_out || bad_wraps != 0) begin
         tests_failed++;
         $display("FAIL period_stray: timeout=%b stray_wraps=%0d, want 0 0", timed_out, bad_wraps);
      end
      cyc();
   endtask

   task automatic test_zero_seed();
      seed = 8'h00; load = 1'b1;
      cyc();
      load = 1'b0;
      tests_run++;
      if (state_f !== 8'h01 || sfix_f !== 1'b1 || adv_f !== 1'b0 || wrap_f !== 1'b0 || period_f !== 8'd255) begin
         tests_failed++;
         $display("FAIL zero_seed: state=%h sfix=%b adv=%b wrap=%b period=%0d, want 01 1 0 0 255",
                  state_f, sfix_f, adv_f, wrap_f, period_f);
      end
      seed = 8'h37; load = 1'b1;
      cyc();
      load = 1'b0;
      tests_run++;
      if (state_f !== 8'h37 || sfix_f !== 1'b0) begin
         tests_failed++;
         $display("FAIL reseed: state=%h sfix=%b, want 37 0", state_f, sfix_f);
      end
   endtask

   task automatic test_priority();
      seed = 8'h01; load = 1'b1; run = 1'b1;
      cyc();
      load = 1'b0;
      cyc(); cyc(); cyc();
      // divider now sits at its terminal count, so a tick coincides with load and step
      seed = 8'h44; load = 1'b1; step = 1'b1;
      cyc();
      load = 1'b0; step = 1'b0; run = 1'b0;
      tests_run++;
      if (state_f !== 8'h44 || adv_f !== 1'b0 || wrap_f !== 1'b0) begin
         tests_failed++;
         $display("FAIL prio_load: state=%h adv=%b wrap=%b, want 44 0 0", state_f, adv_f, wrap_f);
      end
      step = 1'b1;
      cyc();
      step = 1'b0;
      tests_run++;
      if (state_f !== 8'h88 || adv_f !== 1'b1) begin
         tests_failed++;
         $display("FAIL prio_step: state=%h adv=%b, want 88 1", state_f, adv_f);
      end
      cyc();
      tests_run++;
      if (state_f !== 8'h88 || adv_f !== 1'b0) begin
         tests_failed++;
         $display("FAIL prio_single: state=%h adv=%b, want 88 0", state_f, adv_f);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      seed = 8'h01; load = 1'b1; run = 1'b1;
      cyc();
      load = 1'b0;
      cyc(); cyc(); cyc();
      step = 1'b1;
      cyc();
      step = 1'b0;
      tests_run++;
      if (state_f !== 8'h02 || adv_f !== 1'b1) begin
         tests_failed++;
         $display("FAIL step_tick_once: state=%h adv=%b, want 02 1", state_f, adv_f);
      end
      n = 0;
      do begin
         cyc();
         n++;
      end while (adv_f !== 1'b1 && n < 10);
      run = 1'b0;
      tests_run++;
      if (state_f !== 8'h04 || n != 4) begin
         tests_failed++;
         $display("FAIL tick_consumed: state=%h after %0d cycles, want 04 after 4", state_f, n);
      end
      cyc();
   endtask

   task automatic test_async_reset();
      seed = 8'h5A; load = 1'b1; run = 1'b1;
      cyc();
      load = 1'b0;
      repeat (6) cyc();
      @(negedge clk_50m);
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if (state_f !== 8'h01 || period_f !== 8'h00 || adv_f !== 1'b0 || wrap_f !== 1'b0) begin
         tests_failed++;
         $display("FAIL async_reset: state=%h period=%h adv=%b wrap=%b, want 01 00 0 0",
                  state_f, period_f, adv_f, wrap_f);
      end
      run = 1'b0;
      cyc();
      rst = 1'b0;
      repeat (6) cyc();
      tests_run++;
      if (state_f !== 8'h01 || adv_f !== 1'b0 || period_f !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_release_hold: state=%h adv=%b period=%h, want 01 0 00", state_f, adv_f, period_f);
      end
   endtask

   initial begin
      test_reset();
      test_fib_run();
      test_galois_step();
      test_period();
      test_zero_seed();
      test_priority();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised successor to the 8-bit Fibonacci LFSR display block.
- Provides a WIDTH-bit LFSR that runs in either Fibonacci or Galois form.
- Steps on an internal divided tick or on demand; supports runtime seed load and zero-lock-up protection.
- Detects when the sequence returns to its seed and reports the measured period.
- Sits between the switch/key inputs and the seven-segment hex encoders on the 50 MHz board clock.

Parameters:
- WIDTH, 8: LFSR length in bits; legal range 3..16.
- MODE, 0: 0 = Fibonacci (external XOR), 1 = Galois (internal XOR).
- FIB_TAPS, 8'hB8: Fibonacci feedback mask; bit i set means state[i] feeds the XOR. Bit WIDTH-1 must be 1.
- GAL_POLY, 8'h71: Galois polynomial without the x^WIDTH term. The defaults for both modes encode x^8+x^6+x^5+x^4+1.
- CLK_DIV, 50_000_000: clk_50m cycles per auto step; legal range ≥2.
- SEED_RST, 1: state and reference seed after reset; must be nonzero.

Ports:
- clk_50m, input, 1: system clock, 50 MHz.
- rst, input, 1: asynchronous, active-high reset.
- seed, input, WIDTH: seed value, used when load=1.
- load, input, 1: synchronous seed load strobe.
- run, input, 1: level signal; enables auto stepping from the divider.
- step, input, 1: single manual step strobe, one cycle wide.
- state, output, WIDTH: current LFSR value.
- advance, output, 1: one-cycle pulse in the cycle after state changed.
- wrap, output, 1: one-cycle pulse when the new state equals the reference seed.
- period, output, WIDTH: number of steps in the last completed cycle. Holds 0 until the first wrap.
- seed_fixed, output, 1: set when the last load carried an all-zero seed.

Behaviour:
- Reset (async assert, sync-safe release):
  - state = SEED_RST; ref = SEED_RST.
  - Step count = 0; period = 0; divider = 0.
  - advance = 0; wrap = 0; seed_fixed = 0.
- Fibonacci next state: fb = XOR of (state & FIB_TAPS); next = {state[WIDTH-2:0], fb}.
- Galois next state: msb = state[WIDTH-1]; next = {state[WIDTH-2:0], 1'b0} ^ (msb ? GAL_POLY : 0).
- Divider:
  - Counts 0..CLK_DIV-1 while run=1, producing a tick on the terminal count, then returns to 0.
  - When run=0 it holds its value (it does not clear).
  - load clears it.
- Priority per cycle: load > step > tick.
  - step and tick in the same cycle give one step only.
  - A tick that coincides with a step is consumed, not deferred.
- load:
  - state = ref = seed, or 1 if seed==0. seed_fixed is set to (seed==0).
  - Step count = 0. period is unchanged.
  - No advance or wrap pulse is produced.
- Step:
  - state <= next; step count increments.
  - advance is asserted on the next cycle (registered, latency 1).
- Wrap: if next == ref at a step:
  - wrap pulses together with advance.
  - period <= count+1 (modulo 2^WIDTH; a maximal 8-bit sequence gives 255).
  - Step count is reset to 0.
- All-zero state is unreachable by construction. The block never enters it and needs no recovery path.
- run is level-sensitive; step is not edge-detected (the upstream debouncer delivers single-cycle strobes).
- Reset mid-count aborts the count immediately; period returns to 0.

Test Plan:
- Fibonacci, defaults, CLK_DIV=4: load seed 0x01, run=1 → state sequence 01,02,04,08,11,23 with one step every 4 cycles; advance pulses each step.
- MODE=1, same seed: step ×10 → sequence 01,02,04,08,10,20,40,80,71,E2,B5.
- Period check: Fibonacci seed 0x5A, run=1 → after 255 steps state=0x5A, wrap pulses once, period=255; the second wrap occurs 255 steps later.
- Zero seed: load seed 0x00 → state=0x01, seed_fixed=1. A following load of 0x37 → seed_fixed=0.
- Priority: assert load=1, step=1 and a tick in the same cycle → state=seed, no advance. Next cycle step=1 alone → one advance.
- Async reset: assert rst between clock edges mid-run → state=0x01 and period=0 immediately. After release with run=0, state holds 0x01.
